// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Force a byte address onto a 4-byte instruction boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel (req/gnt/rvalid).
interface if_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop, clear and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited requests,
// in-order response tagging, wrong-path discard and instruction buffering.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    if_fetch_unit_if.master         imem,
    output logic                    is_a_inst,
    output logic [31:0]             inst,
    output logic [31:0]             pc
);

    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    logic [31:0]   pc_q;
    logic [CW-1:0] disc_cnt;
    logic [CW-1:0] tag_cnt;
    logic [CW-1:0] buf_cnt;
    logic [31:0]   tag_head;
    logic [63:0]   buf_head_bits;
    fetch_entry_t  buf_head;
    fetch_entry_t  buf_in;
    logic [CW:0]   inflight;
    logic          has_credit;
    logic          accept;
    logic          rsp_fire;
    logic          rsp_keep;
    logic          buf_pop;

    // Discarded in-flight requests still hold a tag, so counting tags plus
    // buffered entries guarantees the buffer can never overflow.
    assign inflight   = {1'b0, tag_cnt} + {1'b0, buf_cnt};
    assign has_credit = inflight < (CW+1)'(BUF_DEPTH);

    assign imem.imem_req  = nrst & ~redirect & has_credit;
    assign imem.imem_addr = pc_q;

    assign accept   = imem.imem_req & imem.imem_gnt;
    assign rsp_fire = imem.imem_rvalid & (tag_cnt != '0);
    assign rsp_keep = rsp_fire & ~redirect & (disc_cnt == '0);
    assign buf_pop  = is_a_inst & ~stall & ~redirect;

    assign buf_in   = '{pc: tag_head, inst: imem.imem_rdata};
    assign buf_head = fetch_entry_t'(buf_head_bits);

    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (accept),
        .push_data (pc_q),
        .pop       (rsp_fire),
        .clear     (1'b0),
        .head      (tag_head),
        .count     (tag_cnt)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .nrst      (nrst),
        .push      (rsp_keep),
        .push_data (buf_in),
        .pop       (buf_pop),
        .clear     (redirect),
        .head      (buf_head_bits),
        .count     (buf_cnt)
    );

    // Fetch PC: jump on redirect, otherwise advance one word per grant.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q <= word_align(redirect_pc);
        end else if (accept) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    // Count of stale responses still to be dropped after a redirect.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disc_cnt <= '0;
        end else if (redirect) begin
            disc_cnt <= tag_cnt - CW'(rsp_fire);
        end else if (rsp_fire && disc_cnt != '0) begin
            disc_cnt <= disc_cnt - 1'b1;
        end
    end

    // Present the buffer head, or a NOP bubble when the buffer is empty.
    always_comb begin
        is_a_inst = (buf_cnt != '0);
        inst      = NOP;
        pc        = '0;
        if (is_a_inst) begin
            inst = buf_head.inst;
            pc   = buf_head.pc;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit with a 1-cycle in-order memory model.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        is_a_inst;
    logic [31:0] inst;
    logic [31:0] pc;

    if_fetch_unit_if imem ();

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (4)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem),
        .is_a_inst   (is_a_inst),
        .inst        (inst),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          drop;
    } mreq_t;

    typedef struct {
        string       name;
        bit          st;
        bit          rd;
        logic [31:0] rpc;
        bit          g;
        bit          rs;
        int          cycles;
        bit          exp_req_last;
    } vec_t;

    mreq_t        mem_q[$];
    fetch_entry_t exp_q[$];
    logic [31:0]  model_pc;
    int           n_checks = 0;
    int           n_fail   = 0;
    vec_t         vecs[4];

    logic        s_req;
    logic        s_valid;
    logic [31:0] s_addr;
    logic [31:0] s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, answer from the memory model, compare
    // outputs against the scoreboard, then advance the model to the next edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                        input bit g, input bit rs);
        mreq_t        r;
        bit           rv;
        bit           exp_req;
        int           pre_out;
        fetch_entry_t e;
        @(negedge clk);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        imem.imem_gnt = g;
        rv = rs && (mem_q.size() > 0);
        if (rv) begin
            r = mem_q.pop_front();
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = inst_of(r.addr);
        end else begin
            r = '{addr: 32'h0, drop: 1'b1};
            imem.imem_rvalid = 1'b0;
            imem.imem_rdata  = $urandom;
        end
        pre_out = mem_q.size() + (rv ? 1 : 0);
        #1;
        s_req   = imem.imem_req;
        s_addr  = imem.imem_addr;
        s_valid = is_a_inst;
        s_pc    = pc;
        s_inst  = inst;

        check("is_a_inst", 32'(is_a_inst), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("pc", pc, exp_q[0].pc);
            check("inst", inst, exp_q[0].inst);
        end else begin
            check("pc_idle", pc, 32'h0);
            check("inst_idle", inst, NOP);
        end
        exp_req = !rd && (pre_out + exp_q.size() < 4);
        check("imem_req", 32'(imem.imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem.imem_addr, model_pc);

        if (imem.imem_req && g) mem_q.push_back('{addr: imem.imem_addr, drop: 1'b0});

        if (rd) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].drop = 1'b1;
            model_pc = rpc & ~32'h3;
        end else begin
            if (exp_q.size() != 0 && !st) e = exp_q.pop_front();
            if (rv && !r.drop) exp_q.push_back('{pc: r.addr, inst: inst_of(r.addr)});
            if (exp_req && g) model_pc = model_pc + 32'd4;
        end
    endtask

    task automatic steady(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic reset_mid_burst();
        @(negedge clk);
        nrst = 1'b0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        #1;
        check("rst_req", 32'(imem.imem_req), 32'h0);
        check("rst_valid", 32'(is_a_inst), 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_pc", pc, 32'h0);
        mem_q.delete();
        exp_q.delete();
        model_pc = 32'h0;
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        logic [31:0] held_addr;

        vecs[0] = '{name: "steady_req",  st: 1'b0, rd: 1'b0, rpc: 32'h0, g: 1'b1, rs: 1'b1, cycles: 8, exp_req_last: 1'b1};
        vecs[1] = '{name: "stall_full",  st: 1'b1, rd: 1'b0, rpc: 32'h0, g: 1'b1, rs: 1'b1, cycles: 5, exp_req_last: 1'b0};
        vecs[2] = '{name: "stall_rel",   st: 1'b0, rd: 1'b0, rpc: 32'h0, g: 1'b1, rs: 1'b1, cycles: 6, exp_req_last: 1'b1};
        vecs[3] = '{name: "drain",       st: 1'b0, rd: 1'b0, rpc: 32'h0, g: 1'b0, rs: 1'b1, cycles: 6, exp_req_last: 1'b1};

        nrst = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        imem.imem_gnt = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata = 32'h0;
        model_pc = 32'h0;
        #2;
        nrst = 1'b0;
        #1;
        check("rst_req", 32'(imem.imem_req), 32'h0);
        check("rst_valid", 32'(is_a_inst), 32'h0);
        check("rst_inst", inst, NOP);
        check("rst_pc", pc, 32'h0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        // Table-driven phases; stall phase also checks the output is frozen.
        for (int v = 0; v < 4; v++) begin
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step(vecs[v].st, vecs[v].rd, vecs[v].rpc, vecs[v].g, vecs[v].rs);
                if (vecs[v].st) begin
                    if (c == 0) begin
                        held_pc = s_pc;
                        held_inst = s_inst;
                    end else begin
                        check("stall_pc_frozen", s_pc, held_pc);
                        check("stall_inst_frozen", s_inst, held_inst);
                    end
                end
            end
            check(vecs[v].name, 32'(s_req), 32'(vecs[v].exp_req_last));
        end

        // Redirect with two requests outstanding.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("outstanding2", 32'(mem_q.size()), 32'd2);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1'b0);
        check("redir_req_low", 32'(s_req), 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("redir_req", 32'(s_req), 32'h1);
        check("redir_addr", s_addr, 32'h0000_0100);
        for (int k = 0; k < 10 && !s_valid; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("redir_first_valid", 32'(s_valid), 32'h1);
        check("redir_first_pc", s_pc, 32'h0000_0100);

        // Redirect coinciding with a response and stall.
        steady(3);
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("flush_valid", 32'(s_valid), 32'h0);
        check("flush_inst", s_inst, NOP);
        check("flush_pc", s_pc, 32'h0);

        // Grant withheld for three cycles.
        held_addr = s_addr;
        check("hold_addr_target", held_addr, 32'h0000_0200);
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            check("hold_req", 32'(s_req), 32'h1);
            check("hold_addr", s_addr, held_addr);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("grant_addr", s_addr, held_addr);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("post_grant_addr", s_addr, held_addr + 32'd4);

        // Asynchronous reset mid-burst, then restart at RESET_PC.
        steady(4);
        reset_mid_burst();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("restart_req", 32'(s_req), 32'h1);
        check("restart_addr", s_addr, 32'h0);
        steady(6);

        // PC wraparound at the top of the address space.
        step(1'b0, 1'b1, 32'hFFFF_FFF9, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check("wrap_addr", s_addr, 32'hFFFF_FFF8);
        steady(8);

        // Randomised traffic with occasional redirects.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end
        steady(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
